lsu_mem: RTL and testbench

LSU_MEM -- requirements
Module: lsu_mem

---
 rtl/lsu_mem_if.sv | 31 +++
 rtl/lsu_mem.sv | 241 ++++++++++++++++++++++++
 tb/tb_lsu_mem.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if.sv
// lsu_mem_if: data-bus request/response bundle between the LSU and memory.
// master = LSU side, slave = memory side.
interface lsu_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/lsu_mem.sv
// lsu_mem: single-outstanding load/store unit with ack timeout.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_mem #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  lsu_mem_if.master   bus,
  output logic [31:0] load_data,
  output logic        lsu_done,
  output logic        lsu_stall,
  output logic        lsu_err,
  output logic        lsu_misalign
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [15:0] TO_LAST =
    16'(ACK_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [31:2] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [1:0]  r_off;
  logic        r_sz_b;
  logic        r_sz_h;
  logic        r_uns;
  logic        r_err;
  logic        r_mis;
  logic [31:0] r_load;

  logic        w_accept;
  logic        w_trap;
  logic        w_sz_b;
  logic        w_sz_h;
  logic        w_uns;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_in_req;
  logic        w_ack;
  logic        w_expire;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_lane;

  assign w_accept = mem_valid
                  & (MemRead_mem | MemWrite_mem);
  assign w_in_req = (r_state == S_REQ);
  assign w_ack    = w_in_req & bus.dmem_ack;
  assign w_expire = w_in_req & ~bus.dmem_ack
                  & (r_cnt == TO_LAST);

  // funct3 to access size and signedness
  always_comb begin
    w_sz_b = 1'b0;
    w_sz_h = 1'b0;
    w_uns  = 1'b0;
    unique case (funct3_mem)
      3'b000: w_sz_b = 1'b1;
      3'b001: w_sz_h = 1'b1;
      3'b100: begin
        w_sz_b = 1'b1;
        w_uns  = 1'b1;
      end
      3'b101: begin
        w_sz_h = 1'b1;
        w_uns  = 1'b1;
      end
      default: ;
    endcase
  end

  // lane offset with misaligned low bits dropped
  always_comb begin
    w_off = 2'b00;
    unique case (1'b1)
      w_sz_b:  w_off = addr_mem[1:0];
      w_sz_h:  w_off = {addr_mem[1], 1'b0};
      default: w_off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (w_sz_h & addr_mem[0])
                | (~w_sz_b & ~w_sz_h
                   & (|addr_mem[1:0]));
`else
  assign w_trap = 1'b0;
`endif

  // byte enables and replicated store data
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_mem;
    unique case (1'b1)
      w_sz_b: begin
        w_be    = 4'b0001 << w_off;
        w_wdata = {4{wdata_mem[7:0]}};
      end
      w_sz_h: begin
        w_be    = w_off[1] ? 4'b1100
                           : 4'b0011;
        w_wdata = {2{wdata_mem[15:0]}};
      end
      default: ;
    endcase
  end

  // load lane select and extension
  always_comb begin
    w_byte = bus.dmem_rdata[7:0];
    unique case (r_off)
      2'd0: w_byte = bus.dmem_rdata[7:0];
      2'd1: w_byte = bus.dmem_rdata[15:8];
      2'd2: w_byte = bus.dmem_rdata[23:16];
      2'd3: w_byte = bus.dmem_rdata[31:24];
      default: ;
    endcase
    w_half = r_off[1] ? bus.dmem_rdata[31:16]
                      : bus.dmem_rdata[15:0];
    w_lane = bus.dmem_rdata;
    unique case (1'b1)
      r_sz_b: w_lane = {{24{~r_uns & w_byte[7]}},
                        w_byte};
      r_sz_h: w_lane = {{16{~r_uns & w_half[15]}},
                        w_half};
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = w_trap ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (w_ack || w_expire)
          w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ack timeout counter, cleared while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= 16'd0;
    else if (r_state == S_IDLE)
      r_cnt <= 16'd0;
    else if (w_in_req && !bus.dmem_ack)
      r_cnt <= r_cnt + 16'd1;
  end

  // request capture, completion flags, load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_wdata <= 32'd0;
      r_off   <= 2'b00;
      r_sz_b  <= 1'b0;
      r_sz_h  <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_mis   <= 1'b0;
      r_load  <= 32'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_err <= 1'b0;
            r_mis <= w_trap;
            if (!w_trap) begin
              r_addr  <= addr_mem[31:2];
              r_we    <= MemWrite_mem;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_off   <= w_off;
              r_sz_b  <= w_sz_b;
              r_sz_h  <= w_sz_h;
              r_uns   <= w_uns;
            end
          end
        end
        S_REQ: begin
          if (w_expire)
            r_err <= 1'b1;
          if (w_ack && !r_we)
            r_load <= w_lane;
        end
        default: ;
      endcase
    end
  end

  assign bus.dmem_req   = w_in_req;
  assign bus.dmem_we    = r_we;
  assign bus.dmem_addr  = {r_addr, 2'b00};
  assign bus.dmem_be    = r_be;
  assign bus.dmem_wdata = r_wdata;
  assign load_data      = r_load;

  assign lsu_stall = w_in_req
                   | ((r_state == S_IDLE) & w_accept);
  assign lsu_done  = (r_state == S_DONE)
                   & ~r_err & ~r_mis;
  assign lsu_err   = (r_state == S_DONE) & r_err;

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign = (r_state == S_DONE) & r_mis;
`else
  assign lsu_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed accesses, transaction-level expectation model,
// per-cycle compare process plus literal checks.
module tb_lsu_mem;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] addr_mem;
  logic [31:0] wdata_mem;
  logic [31:0] load_data;
  logic        lsu_done;
  logic        lsu_stall;
  logic        lsu_err;
  logic        lsu_misalign;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_mem_if bus();

  lsu_mem #(.ACK_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_valid    (mem_valid),
    .MemRead_mem  (MemRead_mem),
    .MemWrite_mem (MemWrite_mem),
    .funct3_mem   (funct3_mem),
    .addr_mem     (addr_mem),
    .wdata_mem    (wdata_mem),
    .bus          (bus),
    .load_data    (load_data),
    .lsu_done     (lsu_done),
    .lsu_stall    (lsu_stall),
    .lsu_err      (lsu_err),
    .lsu_misalign (lsu_misalign)
  );

  always #5 clk = ~clk;

  // expected per-cycle outputs
  bit          e_on = 1'b0;
  bit          e_stall, e_req, e_done, e_err, e_mis, e_we;
  logic [31:0] e_addr, e_wd, e_load;
  logic [3:0]  e_be;
  logic [31:0] m_load;

  // observations of the last access
  int          o_cyc, o_stall, o_req, o_done, o_err, o_mis, o_fin;
  logic [31:0] o_addr, o_wd;
  logic [3:0]  o_be;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // model: access rules in plain arithmetic
  function automatic int m_size(logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit m_uns(logic [2:0] f);
    return (f == 3'b100) || (f == 3'b101);
  endfunction

  function automatic int m_off(logic [2:0] f, logic [31:0] a);
    int s;
    s = m_size(f);
    return (int'(a[1:0]) / s) * s;
  endfunction

  function automatic bit m_mis(logic [2:0] f, logic [31:0] a);
    return (int'(a[1:0]) % m_size(f)) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f,
                                      logic [31:0] a);
    return 4'(((1 << m_size(f)) - 1) << m_off(f, a));
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f,
                                       logic [31:0] d);
    case (m_size(f))
      1:       return 32'(d[7:0]) * 32'h0101_0101;
      2:       return 32'(d[15:0]) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_ld(logic [2:0] f,
                                       logic [31:0] a,
                                       logic [31:0] rd);
    int s;
    logic [31:0] v;
    s = m_size(f);
    v = rd >> (8 * m_off(f, a));
    if (s == 1) begin
      v = v & 32'h0000_00FF;
      if (!m_uns(f) && v[7]) v = v | 32'hFFFF_FF00;
    end else if (s == 2) begin
      v = v & 32'h0000_FFFF;
      if (!m_uns(f) && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (e_on) begin
      chk("stall", 32'(lsu_stall), 32'(e_stall));
      chk("req", 32'(bus.dmem_req), 32'(e_req));
      chk("done", 32'(lsu_done), 32'(e_done));
      chk("err", 32'(lsu_err), 32'(e_err));
      chk("misalign", 32'(lsu_misalign), 32'(e_mis));
      chk("load_data", load_data, e_load);
      if (e_req) begin
        chk("we", 32'(bus.dmem_we), 32'(e_we));
        chk("addr", bus.dmem_addr, e_addr);
        chk("be", 32'(bus.dmem_be), 32'(e_be));
        chk("wdata", bus.dmem_wdata, e_wd);
      end
    end
  end

  task automatic set_idle();
    e_stall = 1'b0;
    e_req   = 1'b0;
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_mis   = 1'b0;
    e_load  = m_load;
  endtask

  task automatic clr_obs();
    o_cyc = 0; o_stall = 0; o_req = 0;
    o_done = 0; o_err = 0; o_mis = 0; o_fin = 0;
    o_addr = '0; o_wd = '0; o_be = '0;
  endtask

  task automatic step();
    @(negedge clk);
    o_cyc++;
    if (lsu_stall) o_stall++;
    if (bus.dmem_req) begin
      o_req++;
      o_addr = bus.dmem_addr;
      o_be   = bus.dmem_be;
      o_wd   = bus.dmem_wdata;
    end
    if (lsu_done)     begin o_done++; o_fin = o_cyc; end
    if (lsu_err)      begin o_err++;  o_fin = o_cyc; end
    if (lsu_misalign) begin o_mis++;  o_fin = o_cyc; end
    @(posedge clk);
    #1;
  endtask

  // one access; ackd = REQ cycle index of the ack, -1 = never
  task automatic access(input bit w, input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd,
                        input int ackd,
                        input logic [31:0] rd);
    bit trap;
    bit acked;
    trap  = 1'b0;
    acked = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = m_mis(f3, a);
`endif
    clr_obs();
    mem_valid    = 1'b1;
    MemRead_mem  = !w;
    MemWrite_mem = w;
    funct3_mem   = f3;
    addr_mem     = a;
    wdata_mem    = wd;
    bus.dmem_ack = 1'b0;
    set_idle();
    e_stall = 1'b1;
    step();
    mem_valid    = 1'b0;
    MemRead_mem  = 1'b0;
    MemWrite_mem = 1'b0;
    funct3_mem   = 3'($urandom);
    addr_mem     = $urandom;
    wdata_mem    = $urandom;
    if (!trap) begin
      for (int k = 0; k < TO; k++) begin
        bus.dmem_ack   = (k == ackd);
        bus.dmem_rdata = (k == ackd) ? rd : $urandom;
        e_stall = 1'b1;
        e_req   = 1'b1;
        e_we    = w;
        e_addr  = {a[31:2], 2'b00};
        e_be    = m_be(f3, a);
        e_wd    = m_wd(f3, wd);
        step();
        if (k == ackd) begin
          acked = 1'b1;
          break;
        end
      end
      bus.dmem_ack   = 1'b0;
      bus.dmem_rdata = $urandom;
    end
    if (acked && !w) m_load = m_ld(f3, a, rd);
    set_idle();
    e_done = !trap && acked;
    e_err  = !trap && !acked;
    e_mis  = trap;
    step();
    set_idle();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    mem_valid = 1'b0;
    MemRead_mem = 1'b0;
    MemWrite_mem = 1'b0;
    funct3_mem = 3'b000;
    addr_mem = '0;
    wdata_mem = '0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    m_load = '0;
    clr_obs();
    set_idle();
    e_on = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_addr", bus.dmem_addr, 32'h0);
    chk("rst_be", 32'(bus.dmem_be), 32'h0);
    chk("rst_wdata", bus.dmem_wdata, 32'h0);
    chk("rst_we", 32'(bus.dmem_we), 32'h0);
    chk("rst_load", load_data, 32'h0);
    rst_n = 1'b1;
    step();

    // valid without read/write is not accepted
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;

    // ack while idle is ignored
    bus.dmem_ack = 1'b1;
    bus.dmem_rdata = 32'hFFFF_FFFF;
    clr_obs();
    step();
    step();
    bus.dmem_ack = 1'b0;
    chk("idle_ack_done", 32'(o_done + o_err), 32'd0);

    // SW at 0x1003
    access(1'b1, 3'b010, 32'h1003, 32'hDEAD_BEEF, 0, '0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("sw_mis", 32'(o_mis), 32'd1);
    chk("sw_req", 32'(o_req), 32'd0);
`else
    chk("sw_addr", o_addr, 32'h0000_1000);
    chk("sw_be", 32'(o_be), 32'hF);
    chk("sw_wdata", o_wd, 32'hDEAD_BEEF);
    chk("sw_latency", 32'(o_fin), 32'd3);
    chk("sw_stall", 32'(o_stall), 32'd2);
`endif

    // SB then LB at 0x2002
    access(1'b1, 3'b000, 32'h2002, 32'h0000_0080, 1, '0);
    chk("sb_be", 32'(o_be), 32'h4);
    chk("sb_wdata", o_wd, 32'h8080_8080);
    access(1'b0, 3'b000, 32'h2002, '0, 0, 32'h0080_0000);
    chk("lb_load", load_data, 32'hFFFF_FF80);

    // LHU at 0x3002
    access(1'b0, 3'b101, 32'h3002, '0, 2, 32'hBEEF_1234);
    chk("lhu_be", 32'(o_be), 32'hC);
    chk("lhu_load", load_data, 32'h0000_BEEF);

    // store keeps load_data
    access(1'b1, 3'b010, 32'h5000, 32'h1122_3344, 2, '0);
    chk("sw_keep_load", load_data, 32'h0000_BEEF);

    // ack never returned
    access(1'b0, 3'b010, 32'h6000, '0, -1, '0);
    chk("to_req_cycles", 32'(o_req), 32'd4);
    chk("to_err", 32'(o_err), 32'd1);
    chk("to_done", 32'(o_done), 32'd0);
    chk("to_load", load_data, 32'h0000_BEEF);

    // ack on the last allowed cycle wins
    access(1'b0, 3'b001, 32'h6006, '0, TO - 1, 32'h8001_5555);
    chk("lastack_err", 32'(o_err), 32'd0);
    chk("lastack_done", 32'(o_done), 32'd1);
    chk("lastack_load", load_data, 32'hFFFF_8001);

    // LBU top byte
    access(1'b0, 3'b100, 32'h7003, '0, 0, 32'hF000_0000);
    chk("lbu_load", load_data, 32'h0000_00F0);

    // misaligned LW at 0x4001
    access(1'b0, 3'b010, 32'h4001, '0, 0, 32'hCAFE_F00D);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_pulse", 32'(o_mis), 32'd1);
    chk("mis_req", 32'(o_req), 32'd0);
    chk("mis_load", load_data, 32'h0000_00F0);
`else
    chk("mis_addr", o_addr, 32'h0000_4000);
    chk("mis_done", 32'(o_done), 32'd1);
    chk("mis_load", load_data, 32'hCAFE_F00D);
`endif

    // reset in the second REQ cycle
    clr_obs();
    mem_valid    = 1'b1;
    MemRead_mem  = 1'b1;
    funct3_mem   = 3'b010;
    addr_mem     = 32'h0000_A000;
    wdata_mem    = 32'h0;
    set_idle();
    e_stall = 1'b1;
    step();
    mem_valid   = 1'b0;
    MemRead_mem = 1'b0;
    e_req  = 1'b1;
    e_we   = 1'b0;
    e_addr = 32'h0000_A000;
    e_be   = 4'hF;
    e_wd   = 32'h0;
    step();
    rst_n  = 1'b0;
    m_load = '0;
    set_idle();
    #1;
    chk("arst_req", 32'(bus.dmem_req), 32'd0);
    chk("arst_stall", 32'(lsu_stall), 32'd0);
    chk("arst_addr", bus.dmem_addr, 32'h0);
    chk("arst_load", load_data, 32'h0);
    step();
    rst_n = 1'b1;
    clr_obs();
    step();
    step();
    chk("arst_no_pulse", 32'(o_done + o_err + o_mis), 32'd0);

    // access after reset completes normally
    access(1'b0, 3'b010, 32'h8008, '0, 1, 32'h1357_9BDF);
    chk("post_done", 32'(o_done), 32'd1);
    chk("post_load", load_data, 32'h1357_9BDF);

    e_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
